// File: rtl/mem_pkg.sv
// Shared widths and clear-sequencer state encoding for the data SRAM responder.
package mem_pkg;
   localparam int DATA_W   = 32;
   localparam int LANES    = 4;
   localparam int WORD_OFF = 2;

   typedef enum logic [1:0] {
      CLEAR     = 2'd0,
      DONE_WAIT = 2'd1,
      READY     = 2'd2
   } state_t;
endpackage

// File: rtl/dram_bank.sv
// Single-port word array with byte-lane writes and a registered read port.
module dram_bank
   import mem_pkg::*;
#(
   parameter int IDX_W = 14
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              en,
   input  logic [LANES-1:0]  we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**IDX_W];

   // NOTE: the array has no reset so it maps onto SRAM macros; zeroing is the
   // job of the clear sequencer in the parent.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < LANES; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)              rdata <= '0;
      else if (en && we == '0)  rdata <= mem[idx];
   end

endmodule

// File: rtl/data_sram_responder.sv
// Memory side of the data SRAM port: clear-after-reset, address decode,
// one-cycle read latency, and error reporting.
module data_sram_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_LOG2     = 14,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              data_sram_en,
   input  logic [LANES-1:0]  data_sram_we,
   input  logic [31:0]       data_sram_addr,
   input  logic [DATA_W-1:0] data_sram_wdata,
   output logic [DATA_W-1:0] data_sram_rdata,
   output logic              init_done,
   output logic              addr_err,
   output logic              drop_err
);

   localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : DONE_WAIT;

   state_t                 state, state_nxt;
   logic [DEPTH_LOG2-1:0]  clr_cnt;
   logic [31:0]            off;
   logic                   in_range;
   logic                   user_go;
   logic                   is_read;
   logic                   rd_zero;
   logic                   bank_en;
   logic [LANES-1:0]       bank_we;
   logic [DEPTH_LOG2-1:0]  bank_idx;
   logic [DATA_W-1:0]      bank_wdata;
   logic [DATA_W-1:0]      bank_rdata;
   logic                   unused_addr_lsbs;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= RESET_STATE;
      else         state <= state_nxt;
   end

   // NOTE: default first so every path assigns state_nxt and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:     if (&clr_cnt) state_nxt = READY;
         DONE_WAIT: state_nxt = READY;
         default:   state_nxt = READY;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)             clr_cnt <= '0;
      else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
   end

   assign init_done = (state == READY);

   assign off              = data_sram_addr - BASE_ADDR;
   assign in_range         = (off[31:DEPTH_LOG2+WORD_OFF] == '0);
   assign unused_addr_lsbs = ^off[WORD_OFF-1:0];
   assign user_go          = init_done && data_sram_en;
   assign is_read          = (data_sram_we == '0);

   // Clear sequencer owns the bank until READY; the user port is gated meanwhile.
   always_comb begin
      bank_en    = user_go && in_range;
      bank_we    = data_sram_we;
      bank_idx   = off[DEPTH_LOG2+WORD_OFF-1:WORD_OFF];
      bank_wdata = data_sram_wdata;
      if (state == CLEAR) begin
         bank_en    = 1'b1;
         bank_we    = '1;
         bank_idx   = clr_cnt;
         bank_wdata = '0;
      end
   end

   dram_bank #(.IDX_W(DEPTH_LOG2)) u_bank (
      .clk    (clk),
      .resetn (resetn),
      .en     (bank_en),
      .we     (bank_we),
      .idx    (bank_idx),
      .wdata  (bank_wdata),
      .rdata  (bank_rdata)
   );

   // An out-of-range read masks the bank output to zero until the next good read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_zero  <= 1'b0;
         addr_err <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         if (user_go && is_read) rd_zero <= !in_range;
         addr_err <= user_go && !in_range;
         if (data_sram_en && !init_done) drop_err <= 1'b1;
      end
   end

   assign data_sram_rdata = rd_zero ? '0 : bank_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder with a 16-word array at base 0.
module tb_data_sram_responder;
   localparam int DEPTH_LOG2 = 4;
   localparam int WORDS      = 2**DEPTH_LOG2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        init_done;
   logic        addr_err;
   logic        drop_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model [WORDS];
   logic [31:0] exp_q [$];
   logic [31:0] exp_rdata;

   always #5 clk = ~clk;

   data_sram_responder #(
      .DEPTH_LOG2     (DEPTH_LOG2),
      .BASE_ADDR      (32'h0000_0000),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .init_done       (init_done),
      .addr_err        (addr_err),
      .drop_err        (drop_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < WORDS; i++) model[i] = '0;
      exp_rdata = '0;
   endtask

   // Counts rising edges until init_done; optionally injects one request on clear cycle poke_cyc.
   task automatic wait_init(input string tag, input int poke_cyc);
      int cyc = 0;
      while (!init_done && cyc < 100) begin
         data_sram_en   = (cyc == poke_cyc);
         data_sram_we   = 4'h0;
         data_sram_addr = 32'h0;
         @(posedge clk); #1;
         cyc++;
      end
      data_sram_en = 1'b0;
      check(tag, cyc, WORDS);
   endtask

   // One request cycle; expected read data goes on the scoreboard when driven.
   task automatic access(input string tag, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      logic ok;
      logic [31:0] exp;
      ok = (addr[31:DEPTH_LOG2+2] == '0);
      data_sram_en    = 1'b1;
      data_sram_we    = we;
      data_sram_addr  = addr;
      data_sram_wdata = wdata;
      if (we == 4'h0) exp_q.push_back(ok ? model[addr[DEPTH_LOG2+1:2]] : 32'h0);
      else if (ok) begin
         for (int i = 0; i < 4; i++)
            if (we[i]) model[addr[DEPTH_LOG2+1:2]][8*i +: 8] = wdata[8*i +: 8];
      end
      @(posedge clk); #1;
      data_sram_en = 1'b0;
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         exp_rdata = exp;
      end
      check({tag, "_rdata"}, data_sram_rdata, exp_rdata);
      check({tag, "_addr_err"}, {31'b0, addr_err}, {31'b0, !ok});
   endtask

   task automatic idle(input string tag);
      data_sram_en = 1'b0;
      @(posedge clk); #1;
      check({tag, "_rdata"}, data_sram_rdata, exp_rdata);
      check({tag, "_addr_err"}, {31'b0, addr_err}, 32'h0);
   endtask

   initial begin
      resetn          = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_we    = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      clear_model();
      #12;
      check("rst_rdata", data_sram_rdata, 32'h0);
      check("rst_init_done", {31'b0, init_done}, 32'h0);
      check("rst_addr_err", {31'b0, addr_err}, 32'h0);
      check("rst_drop_err", {31'b0, drop_err}, 32'h0);

      @(posedge clk); #1;
      resetn = 1'b1;
      wait_init("init_cycles", 2);
      check("drop_err_set", {31'b0, drop_err}, 32'h1);
      check("drop_rdata", data_sram_rdata, 32'h0);

      access("rd_3c", 4'h0, 32'h3C, 32'h0);
      access("wr_10_full", 4'hF, 32'h10, 32'hDEAD_BEEF);
      access("wr_10_lane1", 4'b0010, 32'h10, 32'h5555_5555);
      access("rd_10", 4'h0, 32'h10, 32'h0);
      check("merge_const", data_sram_rdata, 32'hDEAD_55EF);

      access("wr_08", 4'hF, 32'h08, 32'h1234_5678);
      access("rd_08_b2b", 4'h0, 32'h08, 32'h0);
      idle("idle_after_rd08");
      check("hold_const", data_sram_rdata, 32'h1234_5678);

      access("rd_40_oor", 4'h0, 32'h40, 32'h0);
      idle("idle_after_oor");
      access("wr_40_oor", 4'hF, 32'h40, 32'hFFFF_FFFF);
      access("rd_00", 4'h0, 32'h00, 32'h0);
      access("rd_40_b2b", 4'h0, 32'h40, 32'h0);
      access("rd_80_b2b", 4'h0, 32'h80, 32'h0);
      access("rd_10_again", 4'h0, 32'h10, 32'h0);
      check("drop_err_sticky", {31'b0, drop_err}, 32'h1);

      access("wr_04", 4'hF, 32'h04, 32'hFFFF_FFFF);
      access("rd_04", 4'h0, 32'h04, 32'h0);
      resetn = 1'b0;
      #1;
      check("midrst_rdata", data_sram_rdata, 32'h0);
      check("midrst_init_done", {31'b0, init_done}, 32'h0);
      check("midrst_drop_err", {31'b0, drop_err}, 32'h0);
      @(posedge clk); #1;
      resetn = 1'b1;
      clear_model();
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      wait_init("reclear_cycles", -1);
      check("reclear_drop_err", {31'b0, drop_err}, 32'h0);
      access("rd_04_cleared", 4'h0, 32'h04, 32'h0);
      access("rd_10_cleared", 4'h0, 32'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
